// File: rtl/rmii_rx_framer.sv
// RMII receive framer: strips preamble/SFD, packs dibits into bytes,
// delimits frames and checks the Ethernet FCS.
// One byte is held back at all times so that the final byte of a frame
// can carry last/error/fcs_ok together with its valid strobe.
module rmii_rx_framer #(
  parameter int MAX_BYTES    = 1522,
  parameter int MAX_PREAMBLE = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       last,
  output logic       error,
  output logic       fcs_ok
);

  localparam int          BCW     = $clog2(MAX_BYTES + 2);
  localparam int          PCW     = $clog2(MAX_PREAMBLE + 2);
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic           crsdv_q;
  logic [1:0]     rxd_q;
  state_t         state_q;
  logic           seen_pre_q;
  logic [PCW-1:0] pre_cnt_q;
  logic [1:0]     dib_cnt_q;
  logic [7:0]     shift_q;
  logic           held_q;
  logic [7:0]     held_byte_q;
  logic [BCW-1:0] byte_cnt_q;
  logic [31:0]    crc_q;
  logic           low_q;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           last_q;
  logic           error_q;
  logic           fcs_ok_q;

  logic [7:0]  byte_d;
  logic [31:0] crc_d;
  logic        frame_err;
  logic        overlen;

  // Byte being completed by the current dibit, and the CRC after absorbing it.
  assign byte_d    = {rxd_q, shift_q[7:2]};
  assign crc_d     = crc32_byte(crc_q, byte_d);
  assign frame_err = (dib_cnt_q != 2'd0) || (int'(byte_cnt_q) < 4);
  assign overlen   = int'(byte_cnt_q) >= MAX_BYTES;

  // Single register stage on the RMII pins; everything else uses this sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      crsdv_q <= 1'b0;
      rxd_q   <= 2'b00;
    end else begin
      crsdv_q <= crsdv;
      rxd_q   <= rxd;
    end
  end

  // Framing FSM with registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      seen_pre_q  <= 1'b0;
      pre_cnt_q   <= '0;
      dib_cnt_q   <= 2'd0;
      shift_q     <= 8'h00;
      held_q      <= 1'b0;
      held_byte_q <= 8'h00;
      byte_cnt_q  <= '0;
      crc_q       <= 32'hFFFFFFFF;
      low_q       <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      error_q     <= 1'b0;
      fcs_ok_q    <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      error_q  <= 1'b0;
      fcs_ok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          low_q <= 1'b0;
          if (crsdv_q) begin
            state_q    <= PREAMBLE;
            pre_cnt_q  <= '0;
            seen_pre_q <= 1'b0;
          end
        end
        PREAMBLE: begin
          if (!crsdv_q) begin
            if (low_q) state_q <= IDLE;
            low_q <= 1'b1;
          end else begin
            low_q <= 1'b0;
            if (int'(pre_cnt_q) >= MAX_PREAMBLE) begin
              state_q <= DROP;
            end else begin
              pre_cnt_q <= pre_cnt_q + PCW'(1);
              case (rxd_q)
                2'b01: seen_pre_q <= 1'b1;
                2'b11: begin
                  if (seen_pre_q) begin
                    state_q    <= DATA;
                    crc_q      <= 32'hFFFFFFFF;
                    byte_cnt_q <= '0;
                    dib_cnt_q  <= 2'd0;
                    held_q     <= 1'b0;
                  end else begin
                    state_q <= DROP;
                  end
                end
                2'b10:   state_q <= DROP;
                default: ;
              endcase
            end
          end
        end
        DATA: begin
          if (crsdv_q) begin
            low_q     <= 1'b0;
            shift_q   <= byte_d;
            dib_cnt_q <= dib_cnt_q + 2'd1;
            if (dib_cnt_q == 2'd3) begin
              if (overlen) begin
                // Frame too long: close it out with an error and discard the rest.
                if (held_q) begin
                  data_q  <= held_byte_q;
                  valid_q <= 1'b1;
                  last_q  <= 1'b1;
                  error_q <= 1'b1;
                end
                held_q  <= 1'b0;
                state_q <= DROP;
              end else begin
                if (held_q) begin
                  data_q  <= held_byte_q;
                  valid_q <= 1'b1;
                end
                held_byte_q <= byte_d;
                held_q      <= 1'b1;
                crc_q       <= crc_d;
                byte_cnt_q  <= byte_cnt_q + BCW'(1);
              end
            end
          end else if (low_q) begin
            // Second consecutive low: end of frame, flush the held byte.
            if (held_q) begin
              data_q   <= held_byte_q;
              valid_q  <= 1'b1;
              last_q   <= 1'b1;
              error_q  <= frame_err;
              fcs_ok_q <= (crc_q == RESIDUE) && !frame_err;
            end
            held_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // A lone low cycle is RMII carrier toggling; nothing is accepted.
            low_q <= 1'b1;
          end
        end
        DROP: begin
          if (!crsdv_q) begin
            if (low_q) state_q <= IDLE;
            low_q <= 1'b1;
          end else begin
            low_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign last   = last_q;
  assign error  = error_q;
  assign fcs_ok = fcs_ok_q;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Testbench for rmii_rx_framer: frames are driven as RMII dibits, expected
// beats are queued when a frame is sent and popped as the DUT emits them.
module tb_rmii_rx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       crsdv;
  logic [1:0] rxd;

  logic [7:0] data,  data8;
  logic       valid, valid8;
  logic       last,  last8;
  logic       error, error8;
  logic       fcs_ok, fcs_ok8;

  rmii_rx_framer dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .data(data), .valid(valid), .last(last), .error(error), .fcs_ok(fcs_ok)
  );

  rmii_rx_framer #(.MAX_BYTES(8)) dut8 (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .data(data8), .valid(valid8), .last(last8), .error(error8), .fcs_ok(fcs_ok8)
  );

  always #10 clk = ~clk;

  // beat = {data, last, error, fcs_ok}
  logic [10:0] q0[$];
  logic [10:0] q8[$];
  logic [7:0]  fb[$];
  bit          en8 = 1'b0;
  int          n_vec = 0;
  int          n_mis = 0;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the end of the test sequence");
    $fatal(1);
  end

  // Scoreboard pop side for the default-parameter DUT.
  always @(negedge clk) begin
    if (valid) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_mis++;
        $display("FAIL extra_beat got %h want no beat", {data, last, error, fcs_ok});
      end else begin
        logic [10:0] e;
        e = q0.pop_front();
        if ({data, last, error, fcs_ok} !== e) begin
          n_mis++;
          $display("FAIL beat got %h want %h", {data, last, error, fcs_ok}, e);
        end
      end
    end
  end

  // Scoreboard pop side for the MAX_BYTES=8 DUT.
  always @(negedge clk) begin
    if (en8 && valid8) begin
      n_vec++;
      if (q8.size() == 0) begin
        n_mis++;
        $display("FAIL extra_beat8 got %h want no beat", {data8, last8, error8, fcs_ok8});
      end else begin
        logic [10:0] e;
        e = q8.pop_front();
        if ({data8, last8, error8, fcs_ok8} !== e) begin
          n_mis++;
          $display("FAIL beat8 got %h want %h", {data8, last8, error8, fcs_ok8}, e);
        end
      end
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (fb[i]) c = crc_upd(c, fb[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
  endtask

  task automatic drive(input logic c, input logic [1:0] d);
    @(negedge clk);
    crsdv = c;
    rxd   = d;
  endtask

  task automatic push_exp(input int which, input int n, input logic err, input logic fok);
    for (int i = 0; i < n; i++) begin
      logic [10:0] b;
      b = (i == n - 1) ? {fb[i], 1'b1, err, fok} : {fb[i], 3'b000};
      if (which == 8) q8.push_back(b);
      else            q0.push_back(b);
    end
  endtask

  task automatic send_preamble(input logic bad);
    for (int i = 0; i < 28; i++) drive(1'b1, (bad && i == 10) ? 2'b10 : 2'b01);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
  endtask

  // Sends preamble, fb[] as dibits, optional extra dibits and a toggle low.
  task automatic send_frame(input int extra, input int toggle_at, input logic bad_pre);
    int idx;
    logic [7:0] b;
    send_preamble(bad_pre);
    idx = 0;
    foreach (fb[i]) begin
      b = fb[i];
      for (int k = 0; k < 4; k++) begin
        if (idx == toggle_at) drive(1'b0, 2'b11);
        drive(1'b1, b[2*k +: 2]);
        idx++;
      end
    end
    for (int k = 0; k < extra; k++) drive(1'b1, 2'b10);
    for (int k = 0; k < 6; k++) drive(1'b0, 2'b00);
  endtask

  task automatic build_good();
    fb = {8'h01, 8'h02, 8'h03, 8'h04};
    append_fcs();
  endtask

  task automatic test_reset();
    rst = 1'b1; crsdv = 1'b0; rxd = 2'b00;
    repeat (2) @(negedge clk);
    n_vec += 5;
    if (data   !== 8'h00) begin n_mis++; $display("FAIL reset_data got %h want 00", data); end
    if (valid  !== 1'b0)  begin n_mis++; $display("FAIL reset_valid got %b want 0", valid); end
    if (last   !== 1'b0)  begin n_mis++; $display("FAIL reset_last got %b want 0", last); end
    if (error  !== 1'b0)  begin n_mis++; $display("FAIL reset_error got %b want 0", error); end
    if (fcs_ok !== 1'b0)  begin n_mis++; $display("FAIL reset_fcs_ok got %b want 0", fcs_ok); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_frame();
    build_good();
    push_exp(0, 8, 1'b0, 1'b1);
    send_frame(0, -1, 1'b0);
    n_vec++;
    if (q0.size() != 0) begin n_mis++; $display("FAIL good_frame_pending got %0d want 0", q0.size()); end
  endtask

  task automatic test_bad_fcs();
    build_good();
    fb[2] = 8'h13;
    push_exp(0, 8, 1'b0, 1'b0);
    send_frame(0, -1, 1'b0);
    n_vec++;
    if (q0.size() != 0) begin n_mis++; $display("FAIL bad_fcs_pending got %0d want 0", q0.size()); end
  endtask

  task automatic test_toggle();
    build_good();
    push_exp(0, 8, 1'b0, 1'b1);
    send_frame(0, 13, 1'b0);
    n_vec++;
    if (q0.size() != 0) begin n_mis++; $display("FAIL toggle_pending got %0d want 0", q0.size()); end
  endtask

  task automatic test_alignment();
    build_good();
    push_exp(0, 8, 1'b1, 1'b0);
    send_frame(2, -1, 1'b0);
    n_vec++;
    if (q0.size() != 0) begin n_mis++; $display("FAIL align_pending got %0d want 0", q0.size()); end
  endtask

  task automatic test_runt();
    fb = {8'hAA, 8'hBB};
    push_exp(0, 2, 1'b1, 1'b0);
    send_frame(0, -1, 1'b0);
    n_vec++;
    if (q0.size() != 0) begin n_mis++; $display("FAIL runt_pending got %0d want 0", q0.size()); end
  endtask

  task automatic test_bad_preamble();
    build_good();
    send_frame(0, -1, 1'b1);
    build_good();
    push_exp(0, 8, 1'b0, 1'b1);
    send_frame(0, -1, 1'b0);
    n_vec++;
    if (q0.size() != 0) begin n_mis++; $display("FAIL bad_pre_pending got %0d want 0", q0.size()); end
  endtask

  task automatic test_overlength();
    fb = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    append_fcs();
    push_exp(0, 12, 1'b0, 1'b1);
    push_exp(8, 8, 1'b1, 1'b0);
    en8 = 1'b1;
    send_frame(0, -1, 1'b0);
    en8 = 1'b0;
    n_vec += 2;
    if (q8.size() != 0) begin n_mis++; $display("FAIL overlen_pending got %0d want 0", q8.size()); end
    if (q0.size() != 0) begin n_mis++; $display("FAIL overlen_ref_pending got %0d want 0", q0.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    build_good();
    push_exp(0, 2, 1'b0, 1'b0);
    q0[1] = {8'h02, 3'b000};
    send_preamble(1'b0);
    for (int i = 0; i < 3; i++) begin
      b = fb[i];
      for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    end
    drive(1'b1, 2'b01);
    drive(1'b1, 2'b01);
    @(negedge clk);
    rst = 1'b1; crsdv = 1'b0; rxd = 2'b00;
    @(negedge clk);
    n_vec += 6;
    if (data   !== 8'h00) begin n_mis++; $display("FAIL midrst_data got %h want 00", data); end
    if (valid  !== 1'b0)  begin n_mis++; $display("FAIL midrst_valid got %b want 0", valid); end
    if (last   !== 1'b0)  begin n_mis++; $display("FAIL midrst_last got %b want 0", last); end
    if (error  !== 1'b0)  begin n_mis++; $display("FAIL midrst_error got %b want 0", error); end
    if (fcs_ok !== 1'b0)  begin n_mis++; $display("FAIL midrst_fcs_ok got %b want 0", fcs_ok); end
    if (q0.size() != 0)   begin n_mis++; $display("FAIL midrst_pending got %0d want 0", q0.size()); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    build_good();
    push_exp(0, 8, 1'b0, 1'b1);
    send_frame(0, -1, 1'b0);
    n_vec++;
    if (q0.size() != 0) begin n_mis++; $display("FAIL after_rst_pending got %0d want 0", q0.size()); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_toggle();
    test_alignment();
    test_runt();
    test_bad_preamble();
    test_overlength();
    test_reset_midframe();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
